// File: rtl/fp_add_pipe.sv
// rtl/fp_add_pipe.sv - three-stage pipelined IEEE-754 adder/subtractor with valid/ready flow control
// S1 unpacks and aligns, S2 adds and normalises, S3 rounds and packs into the output registers.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] IN1,
  input  logic [EXP_W+MAN_W:0] IN2,
  input  logic                 SUB,
  input  logic [2:0]           ROUND_TYPE,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] OUT,
  output logic [4:0]           FLAGS,
  output logic [TAG_W-1:0]     out_tag
);
  localparam int FP_W = 1 + EXP_W + MAN_W;
  localparam int F_W  = MAN_W + 4;
  localparam logic [EXP_W-1:0] E_ONE  = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] E_MAX  = {EXP_W{1'b1}};
  localparam logic [EXP_W:0]   E1_ONE = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [FP_W-1:0]  QNAN   = {1'b0, E_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic int lzc(input logic [F_W-1:0] x);
    int n;
    n = F_W;
    for (int i = 0; i < F_W; i++) begin
      if (x[i]) n = F_W - 1 - i;
    end
    return n;
  endfunction

  logic v1, v2, v3, en1, en2, en3;

  assign en3       = !v3 || out_ready;
  assign en2       = !v2 || en3;
  assign en1       = !v1 || en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  assign sa = IN1[FP_W-1];
  assign ea = IN1[FP_W-2:MAN_W];
  assign ma = IN1[MAN_W-1:0];
  assign sb = IN2[FP_W-1] ^ SUB;
  assign eb = IN2[FP_W-2:MAN_W];
  assign mb = IN2[MAN_W-1:0];

  logic             a_nan, b_nan, a_inf, b_inf, a_snan, b_snan, swap;
  logic             big_s, sml_s, spec, spec_nv;
  logic [EXP_W-1:0] xa, xb, big_e, sml_e, diff;
  logic [MAN_W:0]   ga, gb, big_g, sml_g;
  logic [2*F_W-1:0] wide;
  logic [F_W-1:0]   sml_f;
  logic [FP_W-1:0]  spec_val;
  logic [2:0]       rm_in;
  int unsigned      diff_i;

  always_comb begin
    a_nan  = (ea == E_MAX) && (ma != '0);
    b_nan  = (eb == E_MAX) && (mb != '0);
    a_inf  = (ea == E_MAX) && (ma == '0);
    b_inf  = (eb == E_MAX) && (mb == '0);
    a_snan = a_nan && !ma[MAN_W-1];
    b_snan = b_nan && !mb[MAN_W-1];
    // Raw exponent:mantissa ordering equals magnitude ordering.
    swap   = {eb, mb} > {ea, ma};
    xa     = (ea == '0) ? E_ONE : ea;
    xb     = (eb == '0) ? E_ONE : eb;
    ga     = {ea != '0, ma};
    gb     = {eb != '0, mb};
    big_s  = swap ? sb : sa;
    sml_s  = swap ? sa : sb;
    big_e  = swap ? xb : xa;
    sml_e  = swap ? xa : xb;
    big_g  = swap ? gb : ga;
    sml_g  = swap ? ga : gb;
    diff   = big_e - sml_e;
    diff_i = 32'(diff);
    wide   = {sml_g, 3'b000, {F_W{1'b0}}} >> diff;
    if (diff_i >= MAN_W + 3)
      sml_f = {{(F_W-1){1'b0}}, |sml_g};
    else
      sml_f = {wide[2*F_W-1:F_W+1], wide[F_W] | (|wide[F_W-1:0])};

    spec     = a_nan || b_nan || a_inf || b_inf;
    spec_nv  = a_snan || b_snan || (!a_nan && !b_nan && a_inf && b_inf && (sa != sb));
    spec_val = QNAN;
    if (!a_nan && !b_nan && !(a_inf && b_inf && (sa != sb))) begin
      if (a_inf)      spec_val = {sa, E_MAX, {MAN_W{1'b0}}};
      else if (b_inf) spec_val = {sb, E_MAX, {MAN_W{1'b0}}};
    end
    rm_in = (ROUND_TYPE > 3'd4) ? 3'd0 : ROUND_TYPE;
  end

  logic             s1_sign, s1_esub, s1_spec, s1_nv;
  logic [EXP_W-1:0] s1_exp;
  logic [F_W-1:0]   s1_big, s1_sml;
  logic [FP_W-1:0]  s1_spec_val;
  logic [2:0]       s1_rm;
  logic [TAG_W-1:0] s1_tag;

  logic [F_W:0]     sum;
  logic [F_W-1:0]   n_man;
  logic [EXP_W:0]   n_exp;
  logic             n_sign;
  int               lz, lim, shl;

  always_comb begin
    sum = s1_esub ? ({1'b0, s1_big} - {1'b0, s1_sml}) : ({1'b0, s1_big} + {1'b0, s1_sml});
    lz  = lzc(sum[F_W-1:0]);
    // Normalisation stops at exponent 1 so deep cancellation lands in the subnormal range.
    lim = int'(s1_exp) - 1;
    shl = (lz < lim) ? lz : lim;
    if (sum[F_W]) begin
      n_man = {sum[F_W:2], sum[1] | sum[0]};
      n_exp = {1'b0, s1_exp} + E1_ONE;
    end else begin
      n_man = sum[F_W-1:0] << shl;
      n_exp = {1'b0, s1_exp} - (EXP_W+1)'(shl);
    end
    n_sign = (s1_esub && (sum == '0)) ? (s1_rm == 3'd2) : s1_sign;
  end

  logic             s2_sign, s2_spec, s2_nv;
  logic [EXP_W:0]   s2_exp;
  logic [F_W-1:0]   s2_man;
  logic [FP_W-1:0]  s2_spec_val;
  logic [2:0]       s2_rm;
  logic [TAG_W-1:0] s2_tag;

  logic             lsb, g, r, st, inexact, inc, ovf, to_inf;
  logic [MAN_W+1:0] rnd;
  logic [EXP_W:0]   e_full;
  logic [MAN_W-1:0] mant;
  logic [FP_W-1:0]  res;
  logic [4:0]       flg;

  always_comb begin
    lsb     = s2_man[3];
    g       = s2_man[2];
    r       = s2_man[1];
    st      = s2_man[0];
    inexact = g || r || st;
    case (s2_rm)
      3'd1:    inc = 1'b0;
      3'd2:    inc = inexact && s2_sign;
      3'd3:    inc = inexact && !s2_sign;
      3'd4:    inc = g;
      default: inc = g && (r || st || lsb);
    endcase
    rnd = {1'b0, s2_man[F_W-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    if (rnd[MAN_W+1]) begin
      e_full = s2_exp + E1_ONE;
      mant   = rnd[MAN_W:1];
    end else if (rnd[MAN_W]) begin
      e_full = s2_exp;
      mant   = rnd[MAN_W-1:0];
    end else begin
      e_full = '0;
      mant   = rnd[MAN_W-1:0];
    end
    ovf    = e_full >= {1'b0, E_MAX};
    to_inf = (s2_rm == 3'd0) || (s2_rm == 3'd4) || ((s2_rm == 3'd3) && !s2_sign) ||
             ((s2_rm == 3'd2) && s2_sign);
    if (ovf) begin
      res = to_inf ? {s2_sign, E_MAX, {MAN_W{1'b0}}}
                   : {s2_sign, E_MAX - E_ONE, {MAN_W{1'b1}}};
      flg = 5'b00101;
    end else begin
      res = {s2_sign, e_full[EXP_W-1:0], mant};
      flg = {3'b000, (e_full == '0) && inexact, inexact};
    end
    if (s2_spec) begin
      res = s2_spec_val;
      flg = {s2_nv, 4'b0000};
    end
  end

  always_ff @(posedge clk) begin
    if (en1) begin
      s1_sign     <= big_s;
      s1_esub     <= big_s ^ sml_s;
      s1_exp      <= big_e;
      s1_big      <= {big_g, 3'b000};
      s1_sml      <= sml_f;
      s1_spec     <= spec;
      s1_spec_val <= spec_val;
      s1_nv       <= spec_nv;
      s1_rm       <= rm_in;
      s1_tag      <= in_tag;
    end
    if (en2) begin
      s2_sign     <= n_sign;
      s2_exp      <= n_exp;
      s2_man      <= n_man;
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
      s2_nv       <= s1_nv;
      s2_rm       <= s1_rm;
      s2_tag      <= s1_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      v3      <= 1'b0;
      OUT     <= '0;
      FLAGS   <= '0;
      out_tag <= '0;
    end else begin
      if (en1) v1 <= in_valid;
      if (en2) v2 <= v1;
      if (en3) begin
        v3 <= v2;
        if (v2) begin
          OUT     <= res;
          FLAGS   <= flg;
          out_tag <= s2_tag;
        end
      end
    end
  end
endmodule

// File: doc/fp_add_pipe.md
# fp_add_pipe

Parametrised, pipelined IEEE-754 floating-point adder/subtractor with valid/ready handshakes, all five rounding modes, full subnormal support and exception flags. It succeeds the combinational `fp_add` in `basic-design`. It is the add datapath the fused units instantiate when they need one result per cycle under backpressure. The default configuration is binary32.

## Interface
- `EXP_W`, 8: exponent width.
- `MAN_W`, 23: stored mantissa width (hidden bit excluded). `FP_W = 1+EXP_W+MAN_W`.
- `TAG_W`, 4: width of the opaque tag carried alongside each operation.
- `clk`  in  1: clock; all state updates on its rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `in_valid`  in  1: operation presented.
- `in_ready`  out  1: block can accept an operation this cycle.
- `IN1`, `IN2`  in  FP_W: operands.
- `SUB`  in  1: 1 computes `IN1 - IN2` by inverting the sign of `IN2`.
- `ROUND_TYPE`  in  3: rounding mode, using the `define.sv` macros. `ROUND_RTNE`=0, `ROUND_RTZ`=1, `ROUND_RDN`=2, `ROUND_RUP`=3, `ROUND_RMM`=4. Values 5–7 are treated as RTNE.
- `in_tag`  in  TAG_W: returned unchanged with the result.
- `out_valid`  out  1: result presented.
- `out_ready`  in  1: consumer accepts the result this cycle.
- `OUT`  out  FP_W: result.
- `FLAGS`  out  5: {NV, DZ, OF, UF, NX}. DZ is always 0.
- `out_tag`  out  TAG_W: tag of the result.

## Operation
- **Transfer rules.** An input transfer occurs when `in_valid & in_ready` at a clock edge. An output transfer occurs when `out_valid & out_ready`. Results leave in acceptance order.
- **S1 (unpack/align)**
  - Classify each operand (zero, subnormal, normal, inf, NaN). A subnormal takes effective exponent 1 and hidden bit 0.
  - Swap so that the operand with the larger magnitude is first.
  - Right-shift the smaller significand by the exponent difference into a field of `MAN_W+4` bits: guard, round, and a sticky bit that ORs every shifted-out bit. A difference of at least `MAN_W+3` collapses the smaller operand to sticky only.
- **S2 (add/normalise)**
  - Effective operation is subtract when the signs differ.
  - Add or subtract with 1 bit of carry headroom.
  - On carry-out, shift right 1 and increment the exponent, folding the dropped bit into sticky.
  - Otherwise, run a leading-zero count and shift left by `min(lzc, exp-1)`. This limit makes an underflow into the subnormal range produce a subnormal with exponent field 0.
- **S3 (round/pack)**
  - Apply the rounding mode to guard/round/sticky:
    - RTNE: increment on G&(R|S|LSB).
    - RTZ: never increment.
    - RDN: increment if negative and inexact.
    - RUP: increment if positive and inexact.
    - RMM: increment on G.
  - A carry out of the mantissa increments the exponent.
  - Overflow to the all-ones exponent gives inf for RTNE and RMM, and for RUP when positive or RDN when negative. Otherwise it gives the largest finite value of that sign. Overflow sets OF and NX.
  - NX is set when any of G/R/S is set. UF is set when the result is tiny (exponent field 0 after rounding, or exactly 0 from a nonzero exact result) and inexact.
- **Special cases**, decided in S1 and forwarded as an override:
  - Any NaN operand gives the canonical qNaN: sign 0, exponent all ones, mantissa MSB 1, rest 0 (0x7FC00000 in binary32). NV is set if either NaN is signalling.
  - inf + (−inf) gives the qNaN with NV.
  - inf + finite gives that inf.
- **Signed zeros.** An exact zero sum of opposite-sign operands is +0, or −0 under RDN. Zero + zero of the same sign keeps that sign.
- **Metadata.** `ROUND_TYPE`, `SUB` and `in_tag` are captured at input transfer and travel with their operation. Changing them later does not affect operations already in flight.

## Timing
- **Stages.** 3 registered stages (S1→S2→S3), each with its own valid bit. Results come from S3 registers with no combinational path from `IN1`/`IN2` to `OUT`.
- **Latency.** An operation accepted at edge N has `out_valid`=1 in the cycle after edge N+2, i.e. 3 edges, provided there is no stall.
- **Throughput.** 1 operation per cycle.
- **Stage advance.** Stage k advances when stage k+1 is empty or advancing. S3 advances on `out_ready` or when it is empty.
- **Ready.** `in_ready = !v1 | adv1`. This may depend combinationally on `out_ready`; there is no dependence on `in_valid`.
- **Stall.** While `out_valid & !out_ready`, `OUT`, `FLAGS` and `out_tag` are held stable. Bubbles compress.
  - With the output stalled, exactly 3 operations can be held.
  - `in_ready` drops in the cycle that all 3 valid bits are set and `out_ready`=0.
- **Reset.**
  - Clears all valid bits on the edge with `rst`=1. Then `out_valid`=0, `in_ready`=1, and `OUT`, `FLAGS`, `out_tag` read 0.
  - Data registers need not reset.
  - A reset mid-operation discards every in-flight operation, and no stale result appears afterwards.
  - An input offered during reset is not accepted.
- **Simultaneous transfers.** An input and an output transfer in the same cycle are both legal and keep the pipeline full.

## Test plan
- **Basic adds, RTNE.** `0x3FC00000+0x3FC00000` → `0x40400000`, flags 0. `0xBFE00000+0x3FF00000` → `0x3E000000`. `SUB`=1 with `0x40000000`,`0x3F800000` → `0x3F800000`. Each appears 3 cycles after acceptance.
- **Zero sign and rounding.**
  - `0x3F800000+0xBF800000` → `0x00000000` under RTNE, `0x80000000` under RDN.
  - `0x3F800000+0x33800000` → `0x3F800000` with NX under RTNE, `0x3F800001` with NX under RUP.
- **Overflow and specials.**
  - `0x7F7FFFFF+0x7F7FFFFF` → `0x7F800000` with OF|NX under RTNE, `0x7F7FFFFF` with OF|NX under RTZ.
  - `0x7F800000+0xFF800000` → `0x7FC00000` with NV.
  - `0x7F800001+0x3F800000` → `0x7FC00000` with NV.
- **Subnormals.** `0x00000001+0x00000001` → `0x00000002`, flags 0. `0x00800000+0x80000001` → `0x007FFFFF`, flags 0.
- **Backpressure.** Stream 6 operations with tags 0–5 while holding `out_ready`=0 for 6 cycles.
  - `in_ready` falls after 3 accepts.
  - `OUT` is stable throughout the stall.
  - After `out_ready` is released, all 6 results are delivered in tag order with no loss or duplication.
- **Reset mid-flight.** Accept 2 operations and assert `rst` for 1 cycle. Then `out_valid`=0 and `in_ready`=1. A new operation afterwards returns its own result at latency 3, with no stale output.
